// File: rtl/latch_bank_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// latch_bank_arbiter: round-robin write sequencer for a bank of enabled D latches
// Rev 1.0
// ---------------------------------------------------------------------------
module latch_bank_arbiter #(
   parameter int NREQ   = 4,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NREQ-1:0]         req_i,
   input  logic [NREQ*ADDR_W-1:0]  wr_addr_i,
   input  logic [NREQ*WIDTH-1:0]   wr_data_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [NREQ-1:0]         done_o,
   output logic                    busy_o,
   output logic [WIDTH-1:0]        latch_d_o,
   output logic [2**ADDR_W-1:0]    latch_en_o
);

   localparam int NWORD = 2**ADDR_W;
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ENABLE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   winner_q, winner_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;
   logic [NREQ-1:0]    done_q, done_d;
   logic               busy_q, busy_d;
   logic [NWORD-1:0]   en_q, en_d;

   logic               found;
   int                 pick;
   int                 idx;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      winner_d = winner_q;
      addr_d   = addr_q;
      data_d   = data_q;
      gnt_d    = gnt_q;
      done_d   = done_q;
      busy_d   = busy_q;
      en_d     = en_q;
      found    = 1'b0;
      pick     = 0;
      idx      = 0;

      case (state_q)
         IDLE: begin
            // First requester at or above ptr, wrapping round to zero.
            for (int off = 0; off < NREQ; off++) begin
               idx = (int'(ptr_q) + off) % NREQ;
               if (!found && req_i[idx]) begin
                  found = 1'b1;
                  pick  = idx;
               end
            end
            if (found) begin
               state_d     = SETUP;
               winner_d    = PTR_W'(pick);
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               addr_d      = wr_addr_i[pick*ADDR_W +: ADDR_W];
               data_d      = wr_data_i[pick*WIDTH +: WIDTH];
               busy_d      = 1'b1;
            end
         end
         SETUP: begin
            state_d        = ENABLE;
            en_d           = '0;
            en_d[addr_q]   = 1'b1;
         end
         ENABLE: begin
            state_d = HOLD;
            en_d    = '0;
            done_d  = gnt_q;
         end
         HOLD: begin
            state_d = IDLE;
            done_d  = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = (winner_q == PTR_W'(NREQ-1)) ? '0 : winner_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Enables are flops, so reset drops them without waiting for a clock.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         winner_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         en_q     <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         winner_q <= winner_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign busy_o     = busy_q;
   assign latch_d_o  = data_q;
   assign latch_en_o = en_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
`default_nettype none
// Directed bench for latch_bank_arbiter: vector table of whole transactions
// plus hand-written mid-transaction change, idle hold and reset-in-ENABLE cases.
module tb_latch_bank_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  latch_d;
   logic [3:0]  latch_en;

   int total = 0;
   int bad   = 0;

   latch_bank_arbiter #(.NREQ(4), .WIDTH(8), .ADDR_W(2)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .gnt_o      (gnt),
      .done_o     (done),
      .busy_o     (busy),
      .latch_d_o  (latch_d),
      .latch_en_o (latch_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  gnt;
      logic [3:0]  en;
      logic [7:0]  d;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge with the arbiter in IDLE; returns at the falling
   // edge after the transaction has gone back to IDLE.
   task automatic run_txn(input vec_t v);
      req     = v.req;
      wr_addr = v.addr;
      wr_data = v.data;
      @(posedge clk); @(negedge clk);
      chk("setup_gnt",  32'(gnt), 32'(v.gnt));
      chk("setup_busy", 32'(busy), 32'd1);
      chk("setup_d",    32'(latch_d), 32'(v.d));
      chk("setup_en",   32'(latch_en), 32'd0);
      chk("setup_done", 32'(done), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("enable_en",   32'(latch_en), 32'(v.en));
      chk("enable_d",    32'(latch_d), 32'(v.d));
      chk("enable_done", 32'(done), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("hold_en",   32'(latch_en), 32'd0);
      chk("hold_done", 32'(done), 32'(v.gnt));
      chk("hold_d",    32'(latch_d), 32'(v.d));
      chk("hold_gnt",  32'(gnt), 32'(v.gnt));
      @(posedge clk); @(negedge clk);
      chk("idle_gnt",  32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_en",   32'(latch_en), 32'd0);
      chk("idle_d",    32'(latch_d), 32'(v.d));
   endtask

   vec_t v;

   initial begin
      // Single write, then fairness with all four requesting, then 1001 wrap.
      tbl[0] = '{4'b0001, 8'h02, 32'h0000_00A5, 4'b0001, 4'b0100, 8'hA5};
      tbl[1] = '{4'b1111, 8'hE4, 32'h4433_2211, 4'b0010, 4'b0010, 8'h22};
      tbl[2] = '{4'b1111, 8'hE4, 32'h4433_2211, 4'b0100, 4'b0100, 8'h33};
      tbl[3] = '{4'b1111, 8'hE4, 32'h4433_2211, 4'b1000, 4'b1000, 8'h44};
      tbl[4] = '{4'b1111, 8'hE4, 32'h4433_2211, 4'b0001, 4'b0001, 8'h11};
      tbl[5] = '{4'b1001, 8'hE4, 32'h4433_2211, 4'b1000, 4'b1000, 8'h44};
      tbl[6] = '{4'b1001, 8'hE4, 32'h4433_2211, 4'b0001, 4'b0001, 8'h11};
      tbl[7] = '{4'b1001, 8'hE4, 32'h4433_2211, 4'b1000, 4'b1000, 8'h44};
      tbl[8] = '{4'b1001, 8'hE4, 32'h4433_2211, 4'b0001, 4'b0001, 8'h11};

      rst_n   = 1'b0;
      req     = '0;
      wr_addr = '0;
      wr_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt",  32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_en",   32'(latch_en), 32'd0);
      chk("rst_d",    32'(latch_d), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_txn(tbl[i]);

      // ptr is now 1. Requester 1 alone, then change its inputs during SETUP.
      req     = 4'b0010;
      wr_addr = 8'h08;
      wr_data = 32'h0000_3C00;
      @(posedge clk); @(negedge clk);
      chk("mid_gnt", 32'(gnt), 32'b0010);
      chk("mid_setup_d", 32'(latch_d), 32'h3C);
      req     = 4'b0000;
      wr_data = 32'h0000_FF00;
      wr_addr = 8'h00;
      @(posedge clk); @(negedge clk);
      chk("mid_en",   32'(latch_en), 32'b0100);
      chk("mid_en_d", 32'(latch_d), 32'h3C);
      @(posedge clk); @(negedge clk);
      chk("mid_hold_en", 32'(latch_en), 32'd0);
      chk("mid_done",    32'(done), 32'b0010);
      chk("mid_hold_d",  32'(latch_d), 32'h3C);
      @(posedge clk); @(negedge clk);
      chk("mid_idle_busy", 32'(busy), 32'd0);
      chk("mid_idle_en",   32'(latch_en), 32'd0);
      chk("mid_idle_d",    32'(latch_d), 32'h3C);

      // ptr is now 2: write 0x5A from requester 2, then sit idle.
      v = '{4'b0100, 8'h10, 32'h005A_0000, 4'b0100, 4'b0010, 8'h5A};
      run_txn(v);
      req = 4'b0000;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); @(negedge clk);
         chk("idlehold_en",   32'(latch_en), 32'd0);
         chk("idlehold_d",    32'(latch_d), 32'h5A);
         chk("idlehold_gnt",  32'(gnt), 32'd0);
         chk("idlehold_done", 32'(done), 32'd0);
         chk("idlehold_busy", 32'(busy), 32'd0);
      end

      // ptr is now 3: requester 1 wins via wrap; reset it during ENABLE.
      v = '{4'b0010, 8'h04, 32'h0000_7700, 4'b0010, 4'b0010, 8'h77};
      req     = v.req;
      wr_addr = v.addr;
      wr_data = v.data;
      @(posedge clk); @(negedge clk);
      chk("rstmid_gnt", 32'(gnt), 32'b0010);
      @(posedge clk); @(negedge clk);
      chk("rstmid_en_before", 32'(latch_en), 32'b0010);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_en",   32'(latch_en), 32'd0);
      chk("rstmid_gnt0", 32'(gnt), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_d",    32'(latch_d), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("rstmid_done_edge", 32'(done), 32'd0);
      rst_n = 1'b1;
      run_txn(v);
      req = 4'b0000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
